alu_mult_sequencer: RTL and testbench

- Multi-cycle unsigned multiply controller. It sequences the shared combinational ALU (bit-slice datapath: PASS_B=3'b000, ADD=3'b010) through shift-and-add iterations.
- Sits beside the EX stage. The pipeline hands it operands with a valid/ready handshake, stalls, and takes the low WIDTH bits of the product plus an overflow flag.
- The block holds the accumulator, multiplicand and multiplier registers. The ALU only performs the per-iteration add.

---
 rtl/alu_mult_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_mult_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add unsigned multiply controller that drives a shared combinational ALU.
// Accepts operands in IDLE, iterates once per multiplier bit, and presents the product in DONE.
module alu_mult_sequencer #(
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] product,
   output logic             ovf,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_cntrl,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout
);

   localparam logic [2:0] ALU_PASS_B = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] mplier_shr_s;
   logic             last_iter_s;

   assign mplier_shr_s = mplier_q >> 1;
   assign last_iter_s  = (mplier_shr_s == '0) || (cnt_q == CNT_W'(WIDTH - 1));

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      start_ready = 1'b0;
      out_valid   = 1'b0;
      alu_cntrl   = ALU_PASS_B;

      case (state_q)
         ST_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               mcand_d  = op_a;
               mplier_d = op_b;
               acc_d    = '0;
               cnt_d    = '0;
               ovf_d    = 1'b0;
               state_d  = ST_ITER;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ITER: begin
            alu_cntrl = mplier_q[0] ? ALU_ADD : ALU_PASS_B;
            acc_d     = alu_result;
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_shr_s;
            cnt_d     = cnt_q + CNT_W'(1);
            // A set MSB shifted out while multiplier bits remain would be added later.
            if ((mplier_q[0] && alu_cout) || (mcand_q[WIDTH-1] && (mplier_shr_s != '0))) begin
               ovf_d = 1'b1;
            end else begin
               ovf_d = ovf_q;
            end
            if (last_iter_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ITER;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign product = acc_q;
   assign ovf     = ovf_q;
   assign alu_a   = mcand_q;
   assign alu_b   = acc_q;
   assign alu_cin = 1'b0;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed-vector bench for alu_mult_sequencer with a behavioural bit-slice ALU attached.
module tb_alu_mult_sequencer;

   localparam int W = 64;

   logic         clk;
   logic         reset;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] product;
   logic         ovf;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [2:0]   alu_cntrl;
   logic         alu_cin;
   logic [W-1:0] alu_result;
   logic         alu_cout;
   logic [W:0]   alu_sum_s;

   int n_vec;
   int n_miss;

   alu_mult_sequencer #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_valid(start_valid),
      .start_ready(start_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .product    (product),
      .ovf        (ovf),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cntrl  (alu_cntrl),
      .alu_cin    (alu_cin),
      .alu_result (alu_result),
      .alu_cout   (alu_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU: ADD and PASS_B are the only selects the sequencer uses.
   always_comb begin
      alu_sum_s  = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
      alu_result = '0;
      alu_cout   = 1'b0;
      case (alu_cntrl)
         3'b010: begin
            alu_result = alu_sum_s[W-1:0];
            alu_cout   = alu_sum_s[W];
         end
         3'b000: begin
            alu_result = alu_b;
            alu_cout   = 1'b0;
         end
         default: begin
            alu_result = '0;
            alu_cout   = 1'b0;
         end
      endcase
   end

   task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, wanted %h", tag, got, exp);
      end
   endtask

   task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_p, input logic exp_o,
                           input int exp_n, input int hold);
      int  iters;
      bit  done;
      iters = 0;
      done  = 1'b0;
      @(negedge clk);
      check_vec("idle_ready", {63'd0, start_ready}, 64'd1);
      start_valid = 1'b1;
      op_a        = a;
      op_b        = b;
      out_ready   = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      op_a        = ~a;
      op_b        = ~b;
      for (int k = 0; k < 70 && !done; k++) begin
         if (out_valid) begin
            done = 1'b1;
         end else begin
            check_vec("iter_cntrl", {61'd0, alu_cntrl}, (b[iters] ? 64'd2 : 64'd0));
            iters++;
            @(negedge clk);
         end
      end
      if (!done) begin
         check_vec("timeout_out_valid", 64'd0, 64'd1);
      end
      check_vec("iter_count", 64'(iters), 64'(exp_n));
      check_vec("product", product, exp_p);
      check_vec("ovf", {63'd0, ovf}, {63'd0, exp_o});
      for (int h = 0; h < hold; h++) begin
         start_valid = h[0];
         op_a        = 64'h0BAD_0BAD_0BAD_0BAD;
         op_b        = 64'h0000_0000_0000_0003;
         @(negedge clk);
         check_vec("hold_valid", {63'd0, out_valid}, 64'd1);
         check_vec("hold_product", product, exp_p);
         check_vec("hold_ovf", {63'd0, ovf}, {63'd0, exp_o});
         check_vec("hold_start_ready", {63'd0, start_ready}, 64'd0);
      end
      start_valid = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_vec("drain_valid", {63'd0, out_valid}, 64'd0);
      check_vec("drain_ready", {63'd0, start_ready}, 64'd1);
   endtask

   initial begin
      bit seen_valid;
      n_vec       = 0;
      n_miss      = 0;
      reset       = 1'b1;
      start_valid = 1'b0;
      out_ready   = 1'b0;
      op_a        = '0;
      op_b        = '0;
      repeat (2) @(negedge clk);
      check_vec("rst_start_ready", {63'd0, start_ready}, 64'd1);
      check_vec("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_vec("rst_product", product, 64'd0);
      check_vec("rst_ovf", {63'd0, ovf}, 64'd0);
      check_vec("rst_alu_a", alu_a, 64'd0);
      check_vec("rst_alu_b", alu_b, 64'd0);
      check_vec("rst_alu_cntrl", {61'd0, alu_cntrl}, 64'd0);
      check_vec("rst_alu_cin", {63'd0, alu_cin}, 64'd0);
      reset = 1'b0;

      run_mult(64'd3, 64'd5, 64'd15, 1'b0, 3, 0);
      run_mult(64'h1234, 64'd0, 64'd0, 1'b0, 1, 0);
      run_mult(64'hDEAD, 64'd1, 64'hDEAD, 1'b0, 1, 0);
      run_mult(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64, 0);
      run_mult(64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, 2, 0);
      run_mult(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64, 0);
      run_mult(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 32, 0);
      run_mult(64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1, 33, 0);
      run_mult(64'd3, 64'd5, 64'd15, 1'b0, 3, 10);

      // Abandon 7*0xFF during its second iteration.
      @(negedge clk);
      start_valid = 1'b1;
      op_a        = 64'd7;
      op_b        = 64'hFF;
      @(negedge clk);
      start_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_vec("midrst_start_ready", {63'd0, start_ready}, 64'd1);
      check_vec("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check_vec("midrst_product", product, 64'd0);
      check_vec("midrst_ovf", {63'd0, ovf}, 64'd0);
      seen_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      check_vec("midrst_no_valid", {63'd0, seen_valid}, 64'd0);
      run_mult(64'd6, 64'd7, 64'd42, 1'b0, 3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
